// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the fetch-stage branch predictor: counter states,
// the BTB entry layout and a saturating 32-bit increment used by the perf counters.
package branch_predictor_pkg;

    // Entry fields are sized for the widest supported address; narrower XLEN uses the low bits.
    localparam int BP_MAX_XLEN = 64;

    localparam logic [1:0] SNT     = 2'd0;
    localparam logic [1:0] WNT     = 2'd1;
    localparam logic [1:0] WT      = 2'd2;
    localparam logic [1:0] ST      = 2'd3;
    localparam logic [1:0] CTR_RST = WNT;

    typedef struct packed {
        logic                   valid;
        logic [BP_MAX_XLEN-1:0] tag;
        logic [BP_MAX_XLEN-1:0] target;
        logic [1:0]             ctr;
    } btb_entry_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/branch_predictor_sat_ctr.sv
// 2-bit saturating counter next-state: count up on taken, down on not taken, clamp at 0..3.
// Purely combinational; no latency, no backpressure.
module bp_sat_ctr
    import branch_predictor_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] next_ctr
);

    always_comb begin
        next_ctr = ctr;
        if (taken && (ctr != ST)) begin
            next_ctr = ctr + 2'd1;
        end else if (!taken && (ctr != SNT)) begin
            next_ctr = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: zero-cycle lookup from registered state, trained by
// resolved outcomes one edge later; no handshake, updates are single-cycle pulses.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic            upd_is_branch,
    input  logic            upd_is_jal,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_pred_taken,
    input  logic [XLEN-1:0] upd_pred_target,
    output logic            mispredict,
    output logic [31:0]     br_cnt,
    output logic [31:0]     miss_cnt
);

    localparam int IDX  = $clog2(ENTRIES);
    localparam int TAGW = XLEN - IDX - 2;

    btb_entry_t             table_q [ENTRIES];
    btb_entry_t             lk_entry;
    btb_entry_t             up_entry;
    btb_entry_t             wr_entry;
    logic [IDX-1:0]         lk_idx;
    logic [IDX-1:0]         up_idx;
    logic [BP_MAX_XLEN-1:0] lk_tag;
    logic [BP_MAX_XLEN-1:0] up_tag;
    logic                   up_hit;
    logic                   wr_en;
    logic [1:0]             next_ctr;
    logic [31:0]            br_cnt_q;
    logic [31:0]            miss_cnt_q;
    logic                   unused_bits;

    assign lk_idx = if_pc[IDX+1:2];
    assign up_idx = upd_pc[IDX+1:2];

    always_comb begin
        lk_tag = '0;
        up_tag = '0;
        lk_tag[TAGW-1:0] = if_pc[XLEN-1:IDX+2];
        up_tag[TAGW-1:0] = upd_pc[XLEN-1:IDX+2];
    end

    // Lookup reads the registered table only, so a same-cycle update is seen next cycle.
    assign lk_entry    = table_q[lk_idx];
    assign pred_hit    = lk_entry.valid && (lk_entry.tag == lk_tag);
    assign pred_taken  = pred_hit && lk_entry.ctr[1];
    assign pred_target = pred_taken ? lk_entry.target[XLEN-1:0] : if_pc + XLEN'(4);

    assign up_entry = table_q[up_idx];
    assign up_hit   = up_entry.valid && (up_entry.tag == up_tag);

    bp_sat_ctr u_sat_ctr (
        .ctr      (up_entry.ctr),
        .taken    (upd_taken),
        .next_ctr (next_ctr)
    );

    assign mispredict = upd_valid &&
                        ((upd_taken != upd_pred_taken) ||
                         (upd_taken && (upd_target != upd_pred_target)));

    always_comb begin
        wr_en    = 1'b0;
        wr_entry = up_entry;
        if (upd_valid) begin
            // jal wins when both type bits are set; jalr (neither bit) never trains.
            if (upd_is_jal) begin
                wr_en                       = 1'b1;
                wr_entry.valid              = 1'b1;
                wr_entry.tag                = up_tag;
                wr_entry.target             = '0;
                wr_entry.target[XLEN-1:0]   = upd_target;
                wr_entry.ctr                = ST;
            end else if (upd_is_branch) begin
                if (up_hit) begin
                    wr_en        = 1'b1;
                    wr_entry.ctr = next_ctr;
                    if (upd_taken) begin
                        wr_entry.target           = '0;
                        wr_entry.target[XLEN-1:0] = upd_target;
                    end
                end else if (upd_taken) begin
                    wr_en                     = 1'b1;
                    wr_entry.valid            = 1'b1;
                    wr_entry.tag              = up_tag;
                    wr_entry.target           = '0;
                    wr_entry.target[XLEN-1:0] = upd_target;
                    wr_entry.ctr              = WT;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_RST};
            end
        end else if (wr_en) begin
            table_q[up_idx] <= wr_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (upd_valid) begin
                br_cnt_q <= sat_inc32(br_cnt_q);
            end
            if (mispredict) begin
                miss_cnt_q <= sat_inc32(miss_cnt_q);
            end
        end
    end

    assign br_cnt   = br_cnt_q;
    assign miss_cnt = miss_cnt_q;

    // Low PC bits and the unused high target bits carry no information here.
    assign unused_bits = ^{if_pc[1:0], upd_pc[1:0], lk_entry.target};

endmodule

// File: tb/tb_branch_predictor.sv
// Directed vector table plus randomized traffic checked against an array-based predictor model.
module tb_branch_predictor;

    localparam int NIDX = 16;
    localparam int IDXB = 4;

    localparam int K_NONE = 0;
    localparam int K_BR   = 1;
    localparam int K_JAL  = 2;
    localparam int K_JALR = 3;
    localparam int K_BOTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_hit, pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid, upd_is_branch, upd_is_jal, upd_taken, upd_pred_taken;
    logic [31:0] upd_pc, upd_target, upd_pred_target;
    logic        mispredict;
    logic [31:0] br_cnt, miss_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    branch_predictor #(.XLEN(32), .ENTRIES(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .if_pc           (if_pc),
        .pred_hit        (pred_hit),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .upd_valid       (upd_valid),
        .upd_is_branch   (upd_is_branch),
        .upd_is_jal      (upd_is_jal),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .mispredict      (mispredict),
        .br_cnt          (br_cnt),
        .miss_cnt        (miss_cnt)
    );

    typedef struct {
        logic [31:0] pc;
        int          kind;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic        upt;
        logic [31:0] uptgt;
        logic        eh;
        logic        et;
        logic [31:0] etgt;
        logic        em;
    } vec_t;

    // Reference model: plain arrays indexed by pc bits, counters as ints.
    bit          m_valid [NIDX];
    logic [31:0] m_tag   [NIDX];
    logic [31:0] m_tgt   [NIDX];
    int          m_ctr   [NIDX];
    longint      m_br, m_miss;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] pc, input int kind, input logic [31:0] upc,
                                input logic ut, input logic [31:0] utgt, input logic upt,
                                input logic [31:0] uptgt, input logic eh, input logic et,
                                input logic [31:0] etgt, input logic em);
        vec_t v;
        v.pc = pc; v.kind = kind; v.upc = upc; v.ut = ut; v.utgt = utgt; v.upt = upt;
        v.uptgt = uptgt; v.eh = eh; v.et = et; v.etgt = etgt; v.em = em;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NIDX; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
            m_tgt[i]   = '0;
            m_ctr[i]   = 1;
        end
        m_br   = 0;
        m_miss = 0;
    endtask

    task automatic model_predict(input logic [31:0] pc, output logic h, output logic t,
                                 output logic [31:0] tgt);
        int i;
        i   = int'((pc >> 2) % NIDX);
        h   = m_valid[i] && (m_tag[i] == (pc >> (IDXB + 2)));
        t   = h && (m_ctr[i] >= 2);
        tgt = t ? m_tgt[i] : pc + 32'd4;
    endtask

    function automatic logic model_misp(input vec_t v);
        if (v.kind == K_NONE) return 1'b0;
        return (v.ut != v.upt) || (v.ut && (v.utgt != v.uptgt));
    endfunction

    task automatic model_update(input vec_t v);
        int  i;
        bit  hit;
        logic [31:0] tag;
        if (v.kind == K_NONE) return;
        m_br   = (m_br   >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_br + 1;
        if (model_misp(v)) m_miss = (m_miss >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_miss + 1;
        i   = int'((v.upc >> 2) % NIDX);
        tag = v.upc >> (IDXB + 2);
        hit = m_valid[i] && (m_tag[i] == tag);
        if (v.kind == K_JAL || v.kind == K_BOTH) begin
            m_valid[i] = 1'b1; m_tag[i] = tag; m_tgt[i] = v.utgt; m_ctr[i] = 3;
        end else if (v.kind == K_BR) begin
            if (hit) begin
                m_ctr[i] = v.ut ? ((m_ctr[i] == 3) ? 3 : m_ctr[i] + 1)
                                : ((m_ctr[i] == 0) ? 0 : m_ctr[i] - 1);
                if (v.ut) m_tgt[i] = v.utgt;
            end else if (v.ut) begin
                m_valid[i] = 1'b1; m_tag[i] = tag; m_tgt[i] = v.utgt; m_ctr[i] = 2;
            end
        end
    endtask

    task automatic drive(input vec_t v);
        if_pc           = v.pc;
        upd_valid       = (v.kind != K_NONE);
        upd_is_branch   = (v.kind == K_BR) || (v.kind == K_BOTH);
        upd_is_jal      = (v.kind == K_JAL) || (v.kind == K_BOTH);
        upd_pc          = v.upc;
        upd_taken       = v.ut;
        upd_target      = v.utgt;
        upd_pred_taken  = v.upt;
        upd_pred_target = v.uptgt;
    endtask

    // Called at a falling edge: drive, compare mid-cycle, advance the model, wait for the next fall.
    task automatic step(input vec_t v, input bit use_exp, input string tag);
        logic eh, et, em;
        logic [31:0] etg;
        drive(v);
        #1;
        if (use_exp) begin
            eh = v.eh; et = v.et; etg = v.etgt; em = v.em;
        end else begin
            model_predict(v.pc, eh, et, etg);
            em = model_misp(v);
        end
        check({tag, " pred_hit"},    pred_hit,    eh);
        check({tag, " pred_taken"},  pred_taken,  et);
        check({tag, " pred_target"}, pred_target, etg);
        check({tag, " mispredict"},  mispredict,  em);
        check({tag, " br_cnt"},      br_cnt,      m_br);
        check({tag, " miss_cnt"},    miss_cnt,    m_miss);
        model_update(v);
        @(negedge clk);
    endtask

    vec_t vecs [27];
    vec_t idle;

    initial begin
        vecs[0]  = mk(32'h100, K_NONE, 0, 0, 0, 0, 0,                   0, 0, 32'h104, 0);
        vecs[1]  = mk(32'h100, K_BR,   32'h100, 1, 32'h80,  0, 32'h104, 0, 0, 32'h104, 1);
        vecs[2]  = mk(32'h100, K_NONE, 0, 0, 0, 0, 0,                   1, 1, 32'h80,  0);
        vecs[3]  = mk(32'h100, K_BR,   32'h100, 0, 32'h104, 1, 32'h80,  1, 1, 32'h80,  1);
        vecs[4]  = mk(32'h100, K_NONE, 0, 0, 0, 0, 0,                   1, 0, 32'h104, 0);
        vecs[5]  = mk(32'h100, K_BR,   32'h100, 0, 32'h104, 0, 32'h104, 1, 0, 32'h104, 0);
        vecs[6]  = mk(32'h100, K_BR,   32'h100, 0, 32'h104, 0, 32'h104, 1, 0, 32'h104, 0);
        vecs[7]  = mk(32'h100, K_BR,   32'h100, 1, 32'h80,  0, 32'h104, 1, 0, 32'h104, 1);
        vecs[8]  = mk(32'h100, K_NONE, 0, 0, 0, 0, 0,                   1, 0, 32'h104, 0);
        vecs[9]  = mk(32'h40,  K_JAL,  32'h40,  1, 32'h200, 0, 32'h44,  0, 0, 32'h44,  1);
        vecs[10] = mk(32'h40,  K_NONE, 0, 0, 0, 0, 0,                   1, 1, 32'h200, 0);
        vecs[11] = mk(32'h40,  K_JAL,  32'h440, 1, 32'h500, 0, 32'h444, 1, 1, 32'h200, 1);
        vecs[12] = mk(32'h40,  K_NONE, 0, 0, 0, 0, 0,                   0, 0, 32'h44,  0);
        vecs[13] = mk(32'h440, K_NONE, 0, 0, 0, 0, 0,                   1, 1, 32'h500, 0);
        vecs[14] = mk(32'h440, K_BR,   32'h440, 1, 32'h300, 1, 32'h200, 1, 1, 32'h500, 1);
        vecs[15] = mk(32'h440, K_NONE, 0, 0, 0, 0, 0,                   1, 1, 32'h300, 0);
        vecs[16] = mk(32'h200, K_JALR, 32'h200, 1, 32'h1000, 0, 32'h204, 0, 0, 32'h204, 1);
        vecs[17] = mk(32'h440, K_NONE, 0, 0, 0, 0, 0,                   1, 1, 32'h300, 0);
        vecs[18] = mk(32'h300, K_BOTH, 32'h300, 1, 32'h600, 1, 32'h600, 0, 0, 32'h304, 0);
        vecs[19] = mk(32'h300, K_NONE, 0, 0, 0, 0, 0,                   1, 1, 32'h600, 0);
        vecs[20] = mk(32'h300, K_BR,   32'h300, 0, 32'h304, 1, 32'h600, 1, 1, 32'h600, 1);
        vecs[21] = mk(32'h300, K_NONE, 0, 0, 0, 0, 0,                   1, 1, 32'h600, 0);
        vecs[22] = mk(32'h104, K_BR,   32'h104, 0, 32'h108, 0, 32'h108, 0, 0, 32'h108, 0);
        vecs[23] = mk(32'h104, K_NONE, 0, 0, 0, 0, 0,                   0, 0, 32'h108, 0);
        vecs[24] = mk(32'hFFFF_FFFC, K_NONE, 0, 0, 0, 0, 0,             0, 0, 32'h0,   0);
        vecs[25] = mk(32'h104, K_JALR, 32'h104, 0, 32'h999, 0, 32'h108, 0, 0, 32'h108, 0);
        vecs[26] = mk(32'h104, K_NONE, 32'h104, 1, 32'h999, 0, 32'h108, 0, 0, 32'h108, 0);
        idle     = mk(32'h0, K_NONE, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        rst = 1'b1;
        drive(idle);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 27; i++) begin
            step(vecs[i], 1'b1, $sformatf("vec%0d", i));
        end

        // Asynchronous reset mid-run with an update held across the reset edge.
        drive(mk(32'h300, K_JAL, 32'h300, 1, 32'h700, 0, 32'h304, 0, 0, 0, 0));
        #3 rst = 1'b1;
        #1;
        check("arst pred_hit",    pred_hit,    1'b0);
        check("arst pred_target", pred_target, 32'h304);
        check("arst br_cnt",      br_cnt,      32'h0);
        check("arst miss_cnt",    miss_cnt,    32'h0);
        check("arst mispredict",  mispredict,  1'b1);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(mk(32'h300, K_NONE, 0, 0, 0, 0, 0, 0, 0, 32'h304, 0), 1'b1, "post_rst");

        // Randomized traffic over a few tags per index so aliasing and hits are frequent.
        for (int n = 0; n < 400; n++) begin
            vec_t v;
            logic h, t;
            logic [31:0] tg;
            v = idle;
            v.pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC
                 : ((32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2));
            if ($urandom_range(0, 9) < 7) begin
                v.kind = $urandom_range(1, 4);
                v.upc  = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
                v.ut   = $urandom_range(0, 1);
                v.utgt = $urandom & 32'hFFFF_FFFC;
                if ((v.kind == K_JAL) || (v.kind == K_BOTH)) v.ut = 1'b1;
                if ($urandom_range(0, 1) == 1) begin
                    model_predict(v.upc, h, t, tg);
                    v.upt = t; v.uptgt = tg;
                    if ($urandom_range(0, 2) == 0) v.utgt = tg;
                end else begin
                    v.upt = $urandom_range(0, 1);
                    v.uptgt = $urandom & 32'hFFFF_FFFC;
                end
            end else begin
                v.ut = $urandom_range(0, 1);
                v.upt = $urandom_range(0, 1);
            end
            step(v, 1'b0, $sformatf("rnd%0d", n));
        end

        // Counter saturation from a preloaded near-full value.
        force dut.br_cnt_q   = 32'hFFFF_FFFD;
        force dut.miss_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.br_cnt_q;
        release dut.miss_cnt_q;
        m_br   = 64'hFFFF_FFFD;
        m_miss = 64'hFFFF_FFFE;
        for (int n = 0; n < 4; n++) begin
            step(mk(32'h3C, K_JALR, 32'h200, 1, 32'h10, 0, 32'h204, 0, 0, 0, 0), 1'b0,
                 $sformatf("sat%0d", n));
        end
        drive(idle);
        #1;
        check("sat br_cnt final",   br_cnt,   32'hFFFF_FFFF);
        check("sat miss_cnt final", miss_cnt, 32'hFFFF_FFFF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Front-end branch predictor, the counterpart to the execute-stage branch resolver. In the fetch stage it predicts taken/not-taken and the target for the current PC. It is then trained by the resolved outcome (resolved `jump_flag` and target) that execute feeds back. It combines a direct-mapped branch target buffer (BTB) with a 2-bit saturating-counter history per entry, and provides mispredict detection and performance counters.

## Interface

Parameters:
- `XLEN`, 32: address width.
- `ENTRIES`, 16: number of BTB entries.
  - Must be a power of two, ≥ 2.
  - Derived: `IDX = log2(ENTRIES)`.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `if_pc` in XLEN: fetch PC to predict.
- `pred_hit` out 1: valid entry whose tag matches `if_pc`.
- `pred_taken` out 1: predicted taken.
- `pred_target` out XLEN: predicted next PC.
- `upd_valid` in 1: resolved control-flow instruction this cycle.
- `upd_is_branch` in 1: conditional branch (beq/bne/blt/bge/bltu/bgeu).
- `upd_is_jal` in 1: jal (jalr is never predicted; the resolver still reports it with both type bits 0).
- `upd_pc` in XLEN: PC of the resolved instruction.
- `upd_taken` in 1: resolved jump flag.
- `upd_target` in XLEN: resolved target.
- `upd_pred_taken` in 1: prediction that was made for this instruction.
- `upd_pred_target` in XLEN: predicted target that was made for this instruction.
- `mispredict` out 1: prediction was wrong; redirect fetch.
- `br_cnt` out 32: resolved control-flow count.
- `miss_cnt` out 32: mispredict count.

## Operation

Entry layout:
- `valid`, `tag[XLEN-1:IDX+2]`, `target[XLEN-1:0]`, `ctr[1:0]`.
- Lookup index is `if_pc[IDX+1:2]`; update index is `upd_pc[IDX+1:2]`. Tags use the same split.

Lookup (combinational from registered table):
- `pred_hit = valid & tag match`.
- `pred_taken = pred_hit & ctr[1]`.
- `pred_target = pred_taken ? entry.target : if_pc + 4`. The add is modulo 2^XLEN, so `if_pc = 0xFFFFFFFC` yields `0x00000000`.

Mispredict (combinational):
- `mispredict = upd_valid & ((upd_taken != upd_pred_taken) | (upd_taken & upd_target != upd_pred_target))`.

Update, at the clock edge when `upd_valid = 1`. Hit means a valid entry with a matching tag at the update index.
- Conditional branch, hit:
  - Counter saturating +1 if taken, −1 if not taken, range 0..3.
  - If taken, `target` is also rewritten.
- Conditional branch, miss, taken: allocate/overwrite the entry with `valid = 1`, new tag and target, `ctr = 2` (weakly taken).
- Conditional branch, miss, not taken: no table change.
- jal (hit or miss): write the entry with `valid = 1`, tag, target, `ctr = 3`.
- Neither type bit set (jalr): no table change.
- Both type bits set: illegal; the jal rule applies.

Performance counters:
- `br_cnt` increments on every `upd_valid`.
- `miss_cnt` increments on every `mispredict`.
- Both saturate at 0xFFFFFFFF.

## Timing

- Lookup latency is 0 cycles (same cycle as `if_pc`). Updates are visible to lookup on the cycle after the edge.
- Same-cycle lookup and update to the same index: lookup returns the pre-update contents. There is no bypass.
- There is no handshake. `upd_valid` is a single-cycle pulse per resolved instruction, and back-to-back pulses are legal.
- Back-to-back updates to the same index apply sequentially, one per edge.
- Reset (asynchronous, including mid-operation) forces:
  - all `valid = 0`, all `ctr = 1`, `br_cnt = miss_cnt = 0`.
  - Hence `pred_hit = 0`, `pred_taken = 0`, `pred_target = if_pc + 4`.
  - `mispredict` follows its inputs. There is no state behind it.
- An update coincident with reset deassertion is ignored if `rst` is high at the edge.

## Structure

Shared package:
- Counter constants `SNT = 0`, `WNT = 1`, `WT = 2`, `ST = 3`.
- The BTB entry struct.
- Reset counter value `WNT`.

Sub-module `bp_sat_ctr`:
- 2-bit saturating next-state function with inputs `ctr`, `taken` and output `next_ctr`.
- Instantiated once on the update path.

The table is a register array, because the asynchronous reset clears every valid bit.

## Test plan

- **Reset:** assert `rst`, release; `if_pc = 0x100` → `pred_hit = 0`, `pred_taken = 0`, `pred_target = 0x104`, `br_cnt = 0`, `miss_cnt = 0`.
- **Taken branch allocate and counter training:**
  - Update `upd_pc = 0x100`, branch, taken, target `0x80`, `pred_taken = 0` → `mispredict = 1`.
  - Next cycle, `if_pc = 0x100` → hit, taken, target `0x80`, `ctr = 2`.
  - One not-taken update → `ctr = 1`, `pred_taken = 0`.
  - Two more not-taken updates → `ctr` stays 0.
- **jal and alias overwrite:**
  - jal at `0x40` with target `0x200` → `ctr = 3`.
  - With `ENTRIES = 16`, a jal at `0x440` (same index, different tag) overwrites it.
  - `if_pc = 0x40` now misses, with `pred_target = 0x44`.
- **Target mismatch:** `upd_taken = upd_pred_taken = 1`, `upd_target = 0x300`, `upd_pred_target = 0x200` → `mispredict = 1`, `miss_cnt` +1, entry target becomes `0x300`.
- **Simultaneous lookup and update:** same index on the same cycle → lookup returns old data; new data appears next cycle.
- **Ignored updates and wrap:**
  - jalr update → no table change; `br_cnt` +1.
  - `if_pc = 0xFFFFFFFC` on a miss → `pred_target = 0x00000000`.
  - Counters preloaded (forced) near 0xFFFFFFFF → saturate.
